// File: rtl/mel_output_buffer.sv
// mel_output_buffer
//   Frame buffer between the log-compression stage and the CNN input.
//   While frame_control is in LOG_COMPRESS, the log-mel values coming out of
//   log_lut are written into a MEL_BINS-deep memory. Each value arrives
//   LOG_LAT cycles after its log_en_i/mel_idx_i. Once every bin has been
//   written and output_valid_i is high, the frame is streamed out in bin
//   order over a valid/ready interface. frame_sent_o then pulses for one cycle.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   log_en_i        write request from frame_control (LOG_COMPRESS)
//   mel_idx_i       bin index of the request
//   log_data_i      log_lut result, LOG_LAT cycles after its request
//   output_valid_i  frame_control OUTPUT state
//   m_valid_o/m_ready_i/m_data_o/m_idx_o/m_last_o
//                   CNN stream, one bin per beat, last on bin MEL_BINS-1
//   frame_sent_o    one-cycle pulse after the final handshake
//   overrun_o       sticky: an out-of-range or out-of-phase write was dropped
module mel_output_buffer #(
    parameter int MEL_BINS = 40,
    parameter int DATA_W   = 16,
    parameter int LOG_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        log_en_i,
    input  logic [$clog2(MEL_BINS)-1:0] mel_idx_i,
    input  logic [DATA_W-1:0]           log_data_i,
    input  logic                        output_valid_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [DATA_W-1:0]           m_data_o,
    output logic [$clog2(MEL_BINS)-1:0] m_idx_o,
    output logic                        m_last_o,
    output logic                        frame_sent_o,
    output logic                        overrun_o
);
    localparam int IDX_W = $clog2(MEL_BINS);

    typedef enum logic [1:0] {FILL, WAIT, DRAIN, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [IDX_W-1:0]   rd_addr;
    logic               load_out;
    logic               m_valid_reg, m_valid_next;
    logic [DATA_W-1:0]  m_data_reg;
    logic [IDX_W-1:0]   m_idx_reg;
    logic               m_last_reg;
    logic               frame_sent_reg, frame_sent_next;
    logic               overrun_reg;
    logic               bitmap_clear;
    logic [MEL_BINS-1:0] bitmap_reg, bitmap_set;
    logic               full;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_open, wr_in_range, wr_accept;

    logic [DATA_W-1:0]  mem [MEL_BINS];

    // Align the request with log_lut's output so that wr_en/wr_idx and
    // log_data_i describe the same bin in the same cycle.
    generate
        if (LOG_LAT == 0) begin : g_direct
            assign wr_en  = log_en_i;
            assign wr_idx = mel_idx_i;
        end else begin : g_pipe
            logic             en_pipe_reg  [LOG_LAT];
            logic [IDX_W-1:0] idx_pipe_reg [LOG_LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LOG_LAT; i++) begin
                        en_pipe_reg[i]  <= 1'b0;
                        idx_pipe_reg[i] <= '0;
                    end
                end else begin
                    en_pipe_reg[0]  <= log_en_i;
                    idx_pipe_reg[0] <= mel_idx_i;
                    for (int i = 1; i < LOG_LAT; i++) begin
                        en_pipe_reg[i]  <= en_pipe_reg[i-1];
                        idx_pipe_reg[i] <= idx_pipe_reg[i-1];
                    end
                end
            end

            assign wr_en  = en_pipe_reg[LOG_LAT-1];
            assign wr_idx = idx_pipe_reg[LOG_LAT-1];
        end
    endgenerate

    // Compare one bit wider so that MEL_BINS == 2**IDX_W still works.
    assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(MEL_BINS));
    assign wr_open     = (state_reg == FILL) || (state_reg == WAIT);
    assign wr_accept   = wr_en && wr_open && wr_in_range;

    // A repeated index only re-sets an already-set bit, so it never
    // double-counts toward full.
    generate
        for (genvar gi = 0; gi < MEL_BINS; gi++) begin : g_bitmap
            assign bitmap_set[gi] = wr_accept && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    assign full = &bitmap_reg;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= log_data_i;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rd_ptr_next     = rd_ptr_reg;
        rd_addr         = rd_ptr_reg;
        load_out        = 1'b0;
        m_valid_next    = m_valid_reg;
        frame_sent_next = 1'b0;
        bitmap_clear    = 1'b0;
        case (state_reg)
            FILL: begin
                if (full) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (output_valid_i && full) begin
                    state_next   = DRAIN;
                    rd_ptr_next  = '0;
                    rd_addr      = '0;
                    load_out     = 1'b1;
                    m_valid_next = 1'b1;
                end
            end
            DRAIN: begin
                // output_valid_i is ignored here; a started frame always completes.
                if (m_valid_reg && m_ready_i) begin
                    if (m_last_reg) begin
                        m_valid_next    = 1'b0;
                        frame_sent_next = 1'b1;
                        state_next      = HOLD;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + IDX_W'(1);
                        rd_addr     = rd_ptr_reg + IDX_W'(1);
                        load_out    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!output_valid_i) begin
                    bitmap_clear = 1'b1;
                    state_next   = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FILL;
            rd_ptr_reg     <= '0;
            m_valid_reg    <= 1'b0;
            m_idx_reg      <= '0;
            m_last_reg     <= 1'b0;
            frame_sent_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            bitmap_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            rd_ptr_reg     <= rd_ptr_next;
            m_valid_reg    <= m_valid_next;
            frame_sent_reg <= frame_sent_next;
            if (wr_en && !(wr_open && wr_in_range)) begin
                overrun_reg <= 1'b1;
            end
            if (bitmap_clear) begin
                bitmap_reg <= '0;
            end else begin
                bitmap_reg <= bitmap_reg | bitmap_set;
            end
            if (load_out) begin
                m_idx_reg  <= rd_addr;
                m_last_reg <= (rd_addr == IDX_W'(MEL_BINS-1));
            end else if (frame_sent_next) begin
                m_last_reg <= 1'b0;
            end
        end
    end

    // Registered memory read doubles as the output data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data_reg <= '0;
        end else if (load_out) begin
            m_data_reg <= mem[rd_addr];
        end
    end

    assign m_valid_o    = m_valid_reg;
    assign m_data_o     = m_data_reg;
    assign m_idx_o      = m_idx_reg;
    assign m_last_o     = m_last_reg;
    assign frame_sent_o = frame_sent_reg;
    assign overrun_o    = overrun_reg;
endmodule

// File: tb/tb_mel_output_buffer.sv
// Testbench for mel_output_buffer. Two instances share all stimulus:
// dut_a uses LOG_LAT=1 and dut_b uses LOG_LAT=2. Each gets its log_data line
// delayed to match its latency, so both must produce identical streams.
module tb_mel_output_buffer;
    localparam int MEL_BINS = 40;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              log_en;
    logic [IDX_W-1:0]  mel_idx;
    logic [DATA_W-1:0] log_data_a, log_data_b;
    logic              output_valid;
    logic              m_ready;

    logic              a_valid, a_last, a_sent, a_ovr;
    logic [DATA_W-1:0] a_data;
    logic [IDX_W-1:0]  a_idx;
    logic              b_valid, b_last, b_sent, b_ovr;
    logic [DATA_W-1:0] b_data;
    logic [IDX_W-1:0]  b_idx;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             sb[$];
    logic [DATA_W-1:0] exp_mem [MEL_BINS];

    mel_output_buffer #(.MEL_BINS(MEL_BINS), .DATA_W(DATA_W), .LOG_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .log_en_i(log_en), .mel_idx_i(mel_idx),
        .log_data_i(log_data_a), .output_valid_i(output_valid),
        .m_valid_o(a_valid), .m_ready_i(m_ready), .m_data_o(a_data),
        .m_idx_o(a_idx), .m_last_o(a_last), .frame_sent_o(a_sent),
        .overrun_o(a_ovr)
    );

    mel_output_buffer #(.MEL_BINS(MEL_BINS), .DATA_W(DATA_W), .LOG_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .log_en_i(log_en), .mel_idx_i(mel_idx),
        .log_data_i(log_data_b), .output_valid_i(output_valid),
        .m_valid_o(b_valid), .m_ready_i(m_ready), .m_data_o(b_data),
        .m_idx_o(b_idx), .m_last_o(b_last), .frame_sent_o(b_sent),
        .overrun_o(b_ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one frame; data for index i is base + mul*i.
    task automatic fill(input bit rev, input int base, input int mul);
        logic [DATA_W-1:0] v [MEL_BINS];
        int idx;
        for (int k = 0; k < MEL_BINS + 2; k++) begin
            if (k < MEL_BINS) begin
                idx = rev ? (MEL_BINS - 1 - k) : k;
                v[k] = DATA_W'(base + mul * idx);
                exp_mem[idx] = v[k];
                log_en  = 1'b1;
                mel_idx = IDX_W'(idx);
            end else begin
                log_en  = 1'b0;
                mel_idx = '0;
            end
            log_data_a = (k >= 1 && k <= MEL_BINS) ? v[k-1] : '0;
            log_data_b = (k >= 2) ? v[k-2] : '0;
            @(negedge clk);
        end
        log_data_a = '0;
        log_data_b = '0;
        repeat (4) @(negedge clk);
    endtask

    function automatic bit ready_pat(input int rmode, input int i);
        if (rmode == 0) return 1'b1;
        case ((i - 1) % 4)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Start OUTPUT and consume the frame. Called at a negedge.
    task automatic drain(input int rmode, input int abort_beats, input bit drop_mid, input bit poke);
        beat_t             e;
        int                beats = 0;
        bit                last_hs = 1'b0;
        bit                prev_stall = 1'b0;
        bit                done = 1'b0;
        logic [DATA_W-1:0] pd_a = '0, pd_b = '0;
        logic [IDX_W-1:0]  pi_a = '0, pi_b = '0;
        for (int k = 0; k < MEL_BINS; k++) begin
            e.idx  = IDX_W'(k);
            e.data = exp_mem[k];
            sb.push_back(e);
        end
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_before_output: a=%b b=%b required 0", a_valid, b_valid);
        end
        output_valid = 1'b1;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (a_sent !== last_hs || b_sent !== last_hs) begin
                errors++;
                $display("FAIL frame_sent cyc=%0d: a=%b b=%b required %b", i, a_sent, b_sent, last_hs);
            end
            if (last_hs) begin
                done = 1'b1;
                checks++;
                if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_after_last: a=%b b=%b required 0", a_valid, b_valid);
                end
                $display("frame done: %0d beats, frame_sent seen", beats);
                break;
            end
            checks++;
            if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid_in_drain cyc=%0d: a=%b b=%b required 1", i, a_valid, b_valid);
            end
            if (prev_stall) begin
                checks++;
                if (a_data !== pd_a || a_idx !== pi_a || b_data !== pd_b || b_idx !== pi_b) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d: a=%h/%0d b=%h/%0d required %h/%0d %h/%0d",
                             i, a_data, a_idx, b_data, b_idx, pd_a, pi_a, pd_b, pi_b);
                end
            end
            m_ready = ready_pat(rmode, i);
            if (poke) begin
                if (i == 3) begin
                    log_en = 1'b1; mel_idx = 6'd5; log_data_a = 16'hFFFF; log_data_b = 16'hFFFF;
                end else if (i == 4) begin
                    log_en = 1'b0; mel_idx = '0;
                end else if (i == 6) begin
                    log_data_a = '0; log_data_b = '0;
                end
            end
            if (a_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: idx a=%0d, required no beat", a_idx);
                end else begin
                    e = sb.pop_front();
                    if ({a_data, a_idx, a_last} !== {e.data, e.idx, (e.idx == IDX_W'(MEL_BINS-1))} ||
                        {b_data, b_idx, b_last} !== {e.data, e.idx, (e.idx == IDX_W'(MEL_BINS-1))}) begin
                        errors++;
                        $display("FAIL beat: a=%h/%0d/%b b=%h/%0d/%b required %h/%0d/%b",
                                 a_data, a_idx, a_last, b_data, b_idx, b_last,
                                 e.data, e.idx, (e.idx == IDX_W'(MEL_BINS-1)));
                    end else begin
                        $display("beat idx=%0d data=%h last=%b", a_idx, a_data, a_last);
                    end
                    last_hs = (e.idx == IDX_W'(MEL_BINS-1));
                end
                beats++;
            end
            prev_stall = a_valid && !m_ready;
            pd_a = a_data; pi_a = a_idx; pd_b = b_data; pi_b = b_idx;
            if (drop_mid && beats == 20) output_valid = 1'b0;
            if (abort_beats > 0 && beats == abort_beats) break;
        end
        output_valid = 1'b0;
        m_ready      = 1'b0;
        if (abort_beats > 0) begin
            sb.delete();
        end else if (!done) begin
            errors++;
            $display("FAIL drain_timeout: beats=%0d required %0d", beats, MEL_BINS);
            sb.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if (a_sent !== 1'b0 || b_sent !== 1'b0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL post_frame: sent a=%b b=%b valid a=%b b=%b required 0",
                             a_sent, b_sent, a_valid, b_valid);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; log_en = 1'b0; mel_idx = '0; log_data_a = '0; log_data_b = '0;
        output_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_valid, a_data, a_idx, a_last, a_sent, a_ovr} !== '0 ||
            {b_valid, b_data, b_idx, b_last, b_sent, b_ovr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: a=%b b=%b required all 0",
                     {a_valid, a_data, a_idx, a_last, a_sent, a_ovr},
                     {b_valid, b_data, b_idx, b_last, b_sent, b_ovr});
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_basic;
        fill(1'b0, 0, 3);
        drain(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        fill(1'b0, 7, 5);
        drain(1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_latency;
        fill(1'b1, 1000, 11);
        drain(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun;
        checks++;
        if (a_ovr !== 1'b0 || b_ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_before: a=%b b=%b required 0", a_ovr, b_ovr);
        end
        fill(1'b0, 200, 1);
        drain(1, 0, 1'b0, 1'b1);
        checks++;
        if (a_ovr !== 1'b1 || b_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain: a=%b b=%b required 1", a_ovr, b_ovr);
        end
    endtask

    task automatic test_reset_mid_drain;
        fill(1'b0, 50, 2);
        drain(0, 10, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_valid, a_data, a_idx, a_last, a_sent, a_ovr} !== '0 ||
            {b_valid, b_data, b_idx, b_last, b_sent, b_ovr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain: a=%b b=%b required all 0",
                     {a_valid, a_data, a_idx, a_last, a_sent, a_ovr},
                     {b_valid, b_data, b_idx, b_last, b_sent, b_ovr});
        end
        reset = 1'b0;
        @(negedge clk);
        fill(1'b0, 300, 4);
        drain(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_index;
        checks++;
        if (a_ovr !== 1'b0 || b_ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: a=%b b=%b required 0", a_ovr, b_ovr);
        end
        log_en = 1'b1; mel_idx = 6'd40;
        @(negedge clk);
        log_en = 1'b0; mel_idx = '0; log_data_a = 16'h1234; log_data_b = 16'h1234;
        repeat (4) @(negedge clk);
        log_data_a = '0; log_data_b = '0;
        checks++;
        if (a_ovr !== 1'b1 || b_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_bad_idx: a=%b b=%b required 1", a_ovr, b_ovr);
        end
        fill(1'b0, 400, 1);
        drain(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        fill(1'b0, 0, 1);
        drain(0, 0, 1'b0, 1'b0);
        fill(1'b0, 100, 1);
        drain(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_latency;
        test_overrun;
        test_reset_mid_drain;
        test_bad_index;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mel_output_buffer.md
Name: mel_output_buffer

Overview:
- Frame buffer between the log-compression stage and the CNN input.
- Captures the MEL_BINS log-mel values that log_lut produces while frame_control is in LOG_COMPRESS, at a fixed latency after log_en/mel_idx.
- When frame_control asserts output_valid, streams the frame to the CNN over a valid/ready interface in bin order.
- After the last beat it pulses frame_sent back to frame_control.

Parameters:
- MEL_BINS, 40, number of mel bins per frame.
- DATA_W, 16, width of one log-mel value.
- LOG_LAT, 1, cycles from log_en_i/mel_idx_i to the matching log_data_i; legal range 0..3.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- log_en_i  input  1  frame_control log_en; high during LOG_COMPRESS.
- mel_idx_i  input  $clog2(MEL_BINS)  bin index being compressed.
- log_data_i  input  DATA_W  log_lut result, valid LOG_LAT cycles after its log_en_i/mel_idx_i.
- output_valid_i  input  1  frame_control output_valid; high during OUTPUT.
- m_valid_o  output  1  CNN stream valid.
- m_ready_i  input  1  CNN stream ready.
- m_data_o  output  DATA_W  log-mel value.
- m_idx_o  output  $clog2(MEL_BINS)  bin index of m_data_o.
- m_last_o  output  1  high on the beat with m_idx_o == MEL_BINS-1.
- frame_sent_o  output  1  one-cycle pulse; frame fully consumed.
- overrun_o  output  1  sticky error flag.

Behaviour:
- Reset: all outputs are 0. State is FILL, written bitmap is cleared, and the LOG_LAT delay line is cleared. Memory contents are don't-care.
- Write alignment:
  - log_en_i and mel_idx_i pass through a LOG_LAT-stage register pipe.
  - The delayed pair forms wr_en/wr_idx, which are sampled together with log_data_i.
  - With LOG_LAT=0, writes are direct.
- Write, in FILL or WAIT only:
  - mem[wr_idx] <= log_data_i and bitmap[wr_idx] <= 1.
  - A repeat index overwrites the entry and does not double-count.
  - wr_idx >= MEL_BINS is dropped and sets overrun_o.
- Write in DRAIN or HOLD: dropped, memory unchanged, overrun_o set. overrun_o clears only on reset.
- full = all MEL_BINS bitmap bits set.
- FSM:
  - FILL: go to WAIT when full.
  - WAIT: when output_valid_i and full, go to DRAIN with rd_ptr = 0. The output register loads mem[0] and idx 0, and m_valid_o = 1 on the next cycle. If output_valid_i rises before full, stay in WAIT until full.
  - DRAIN:
    - Handshake = m_valid_o & m_ready_i.
    - On a handshake with rd_ptr < MEL_BINS-1: rd_ptr++, and the output register loads the next entry with no bubble, giving 1 beat/cycle at ready=1.
    - While m_valid_o & !m_ready_i: m_data_o, m_idx_o and m_last_o hold stable.
    - On the handshake with m_last_o = 1: m_valid_o = 0 next cycle, frame_sent_o = 1 for exactly that next cycle, then go to HOLD.
    - If output_valid_i drops mid-DRAIN, draining continues; the stream is not aborted.
  - HOLD: wait for output_valid_i == 0. Frame_control returns to IDLE after frame_sent. Then clear the bitmap and go to FILL. If output_valid_i is already 0, leave HOLD the next cycle.
- frame_sent_o is never asserted outside the cycle after the final handshake.
- m_valid_o must not depend combinationally on m_ready_i.
- Reset mid-operation, in any state: same as power-on reset. m_valid_o drops the next cycle and any partial frame is discarded.
- No arithmetic is performed on data. Counters are $clog2(MEL_BINS) bits and rd_ptr never wraps past MEL_BINS-1.

Test Plan:
- Basic frame, LOG_LAT=1, m_ready_i=1:
  - Stimulus: log_en_i for 40 cycles with idx 0..39 and data = 3*idx, then output_valid_i.
  - Required: m_valid_o rises 1 cycle after output_valid_i is sampled; 40 consecutive beats with data 0,3,…,117 and idx 0..39; m_last_o only on idx 39; frame_sent_o pulses once, on the cycle after the idx-39 handshake.
- Backpressure:
  - Stimulus: m_ready_i toggles 1,0,0,1 repeating.
  - Required: every stalled beat holds data and idx; all 40 values are delivered in order exactly once; frame_sent_o occurs once.
- Latency alignment:
  - Stimulus: LOG_LAT=2 with data driven 2 cycles after each idx, and idx sent in order 39..0.
  - Required: the drained data matches per index.
  - Stimulus: mel_idx_i = 45 (MEL_BINS overridden to 48 with bitmap sized 40 is illegal; instead use MEL_BINS=40 and force idx 40).
  - Required: dropped, and overrun_o = 1.
- Overrun:
  - Stimulus: during DRAIN, pulse log_en_i with idx 5 and data 0xFFFF.
  - Required: overrun_o sets and stays 1; the drained beat idx 5 still carries the original value.
- Back-to-back frames:
  - Stimulus: frame A (data = idx), then frame B (data = 100+idx), with output_valid_i dropping 1 cycle after frame_sent_o.
  - Required: B drains 100..139; no stale A values appear.
- Reset mid-drain:
  - Stimulus: assert reset after beat 10.
  - Required: all outputs are 0 the next cycle; a subsequent full frame drains correctly from idx 0.
